// File: rtl/add_accum_unit.sv
// Registered add/sub/accumulate unit with a valid/ready handshake and a running accumulator.
// Optional macro SATURATE_EN selects unsigned saturation instead of modulo wrap.
module add_accum_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_op_count;

    logic             w_accept;
    logic [WIDTH:0]   w_sum_add;
    logic [WIDTH:0]   w_sum_acc;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic [WIDTH-1:0] w_acc_nxt;

    // Single output register: a new input fits whenever the held result leaves.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    assign w_sum_add = {1'b0, a_in} + {1'b0, b_in};
    assign w_sum_acc = {1'b0, r_acc} + {1'b0, a_in};
    assign w_diff    = a_in - b_in;
    assign w_borrow  = (a_in < b_in);

    // Next result/flags/accumulator for the current operation.
    always_comb begin
        w_res     = '0;
        w_carry   = 1'b0;
        w_acc_nxt = r_acc;
        case (mode)
            MODE_ADD: begin
                w_carry = w_sum_add[WIDTH];
`ifdef SATURATE_EN
                w_res = w_sum_add[WIDTH] ? '1 : w_sum_add[WIDTH-1:0];
`else
                w_res = w_sum_add[WIDTH-1:0];
`endif
            end
            MODE_SUB: begin
                w_carry = w_borrow;
`ifdef SATURATE_EN
                w_res = w_borrow ? '0 : w_diff;
`else
                w_res = w_diff;
`endif
            end
            MODE_ACC: begin
                w_carry = w_sum_acc[WIDTH];
`ifdef SATURATE_EN
                w_res = w_sum_acc[WIDTH] ? '1 : w_sum_acc[WIDTH-1:0];
`else
                w_res = w_sum_acc[WIDTH-1:0];
`endif
                w_acc_nxt = w_res;
            end
            MODE_CLR: begin
                w_res     = '0;
                w_carry   = 1'b0;
                w_acc_nxt = '0;
            end
            default: begin
                w_res     = '0;
                w_carry   = 1'b0;
                w_acc_nxt = r_acc;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_acc       <= '0;
            r_op_count  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_carry     <= w_carry;
            r_zero      <= (w_res == '0);
            r_acc       <= w_acc_nxt;
            r_op_count  <= r_op_count + CNT_W'(1);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign carry     = r_carry;
    assign zero      = r_zero;
    assign acc       = r_acc;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_add_accum_unit.sv
// Directed vector bench for add_accum_unit (WIDTH=8, CNT_W=8).
module tb_add_accum_unit;

`ifdef SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [1:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic [7:0] acc;
    logic [7:0] op_count;

    int n_checks = 0;
    int n_pass   = 0;

    add_accum_unit #(.WIDTH(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .acc       (acc),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_result;
        logic       exp_carry;
        logic       exp_zero;
        logic [7:0] exp_acc;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_result"},    32'(result),    32'd0);
        check({tag, "_carry"},     32'(carry),     32'd0);
        check({tag, "_zero"},      32'(zero),      32'd0);
        check({tag, "_acc"},       32'(acc),       32'd0);
        check({tag, "_op_count"},  32'(op_count),  32'd0);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] exp_cnt;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_in      = '0;
        b_in      = '0;
        mode      = 2'b00;

        //               mode   a      b      result               carry zero         acc
        vecs[0] = '{2'b00, 8'h80, 8'h7F, 8'hFF,                 1'b0, 1'b0,        8'h00};
        vecs[1] = '{2'b00, 8'hFF, 8'h01, SAT ? 8'hFF : 8'h00,   1'b1, !SAT,        8'h00};
        vecs[2] = '{2'b01, 8'h05, 8'h07, SAT ? 8'h00 : 8'hFE,   1'b1, SAT,         8'h00};
        vecs[3] = '{2'b01, 8'h07, 8'h05, 8'h02,                 1'b0, 1'b0,        8'h00};
        vecs[4] = '{2'b10, 8'hF0, 8'h55, 8'hF0,                 1'b0, 1'b0,        8'hF0};
        vecs[5] = '{2'b10, 8'h20, 8'h00, SAT ? 8'hFF : 8'h10,   1'b1, 1'b0,        SAT ? 8'hFF : 8'h10};
        vecs[6] = '{2'b00, 8'h01, 8'h02, 8'h03,                 1'b0, 1'b0,        SAT ? 8'hFF : 8'h10};
        vecs[7] = '{2'b11, 8'hAA, 8'h55, 8'h00,                 1'b0, 1'b1,        8'h00};
        vecs[8] = '{2'b10, 8'h03, 8'hEE, 8'h03,                 1'b0, 1'b0,        8'h03};
        vecs[9] = '{2'b01, 8'h00, 8'h00, 8'h00,                 1'b0, 1'b1,        8'h03};

        #2;
        check_reset_state("por");
        @(negedge clk);
        rst = 1'b0;

        // Table-driven single transactions, out_ready held high.
        exp_cnt = 8'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            mode     = vecs[i].mode;
            a_in     = vecs[i].a;
            b_in     = vecs[i].b;
            @(posedge clk);
            #1;
            exp_cnt++;
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d_result", i),    32'(result),    32'(vecs[i].exp_result));
            check($sformatf("v%0d_carry", i),     32'(carry),     32'(vecs[i].exp_carry));
            check($sformatf("v%0d_zero", i),      32'(zero),      32'(vecs[i].exp_zero));
            check($sformatf("v%0d_acc", i),       32'(acc),       32'(vecs[i].exp_acc));
            check($sformatf("v%0d_op_count", i),  32'(op_count),  32'(exp_cnt));
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("idle_op_count", 32'(op_count), 32'(exp_cnt));

        // Hold with out_ready low, then drain+accept in one cycle, then no bubble.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        mode      = 2'b00;
        a_in      = 8'h01;
        b_in      = 8'h01;
        @(posedge clk);
        #1;
        exp_cnt++;
        check("hold_first_result", 32'(result), 32'h02);
        @(negedge clk);
        a_in = 8'h10;
        b_in = 8'h10;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_in_ready", k),  32'(in_ready),  32'd0);
            check($sformatf("hold%0d_out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("hold%0d_result", k),    32'(result),    32'h02);
            check($sformatf("hold%0d_op_count", k),  32'(op_count),  32'(exp_cnt));
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        exp_cnt++;
        check("drain_accept_out_valid", 32'(out_valid), 32'd1);
        check("drain_accept_result",    32'(result),    32'h20);
        @(negedge clk);
        a_in = 8'h03;
        b_in = 8'h04;
        @(posedge clk);
        #1;
        exp_cnt++;
        check("b2b_result",   32'(result),   32'h07);
        check("b2b_op_count", 32'(op_count), 32'(exp_cnt));
        @(negedge clk);
        in_valid = 1'b0;

        // Asynchronous reset while a result is held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a_in      = 8'h11;
        b_in      = 8'h22;
        @(posedge clk);
        #1;
        check("pre_reset_out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_reset_state("async");
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;

        // op_count wrap: 256 accepts return to 0, the 257th gives 1.
        @(negedge clk);
        in_valid = 1'b1;
        mode     = 2'b00;
        a_in     = 8'h01;
        b_in     = 8'h01;
        for (int k = 0; k < 256; k++) @(posedge clk);
        #1;
        check("wrap256_op_count", 32'(op_count), 32'h00);
        @(posedge clk);
        #1;
        check("wrap257_op_count", 32'(op_count), 32'h01);
        @(negedge clk);
        in_valid = 1'b0;

        do_reset();
        #1;
        check("final_reset_op_count", 32'(op_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
